// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared types and default constants for the two-requester
// mux arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GNT_X, GNT_Y)
//   last_gnt_e  : which requester most recently entered a grant state
//   DEF_WIDTH   : default datapath width
//   DEF_HOLD    : default maximum consecutive grant cycles under contention
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_X = 2'd1,
    GNT_Y = 2'd2
  } arb_state_e;

  typedef enum logic {
    LAST_X = 1'b0,
    LAST_Y = 1'b1
  } last_gnt_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_HOLD  = 4;

endpackage

// File: rtl/mux_arbiter_mux8.sv
// mux8: two-input datapath select used by mux_arbiter.
// Ports:
//   s  (in)         select, 0 picks a, 1 picks b
//   a  (in, WIDTH)  input 0
//   b  (in, WIDTH)  input 1
//   y  (out, WIDTH) selected data (combinational)
module mux8 #(
  parameter int WIDTH = 8
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester arbiter driving a registered 2:1 datapath mux.
// A requester keeps the grant while it requests; when the other side is
// waiting, the owner is preempted after HOLD consecutive grant cycles.
// Ties from IDLE go to the requester that did not win last (X after reset).
//
// state | meaning
// IDLE  | no grant, datapath output holds
// GNT_X | X owns the datapath, s=0
// GNT_Y | Y owns the datapath, s=1
//
// Ports:
//   clock   (in)          rising-edge clock
//   resetn  (in)          asynchronous active-low reset
//   req_x   (in)          requester X request
//   req_y   (in)          requester Y request
//   x       (in, WIDTH)   requester X data
//   y       (in, WIDTH)   requester Y data
//   gnt_x   (out)         X owns the datapath this cycle
//   gnt_y   (out)         Y owns the datapath this cycle
//   s       (out)         mux select, 1 in GNT_Y
//   m       (out, WIDTH)  registered mux output
//   m_valid (out)         m holds granted data
//   LEDR    (out, [9:4])  status LEDs
//
// Build option: MUX_ARBITER_LED_EN drives LEDR with grant/pending/count
// status; when undefined LEDR is tied to zero.
// HOLD must lie in 2..8 so the count fits LEDR[9:7].
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_x,
  input  logic             req_y,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             gnt_x,
  output logic             gnt_y,
  output logic             s,
  output logic [WIDTH-1:0] m,
  output logic             m_valid,
  output logic [9:4]       LEDR
);

  localparam int            CW      = $clog2(HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD - 1);

  arb_state_e    state_q, state_d;
  last_gnt_e     last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic          gnt_x_q, gnt_y_q, s_q, m_valid_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] mux_out;

  mux8 #(.WIDTH(WIDTH)) u_mux (
    .s (s_q),
    .a (x),
    .b (y),
    .y (mux_out)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req_x && (!req_y || last_q == LAST_Y)) begin
          state_d = GNT_X;
        end else if (req_y) begin
          state_d = GNT_Y;
        end
      end
      GNT_X: begin
        if (!req_x) begin
          state_d = req_y ? GNT_Y : IDLE;
        end else if (count_q == CNT_MAX) begin
          // End of a hold window: hand over if Y waits, else start a new window.
          if (req_y) state_d = GNT_Y;
          else       count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      GNT_Y: begin
        if (!req_y) begin
          state_d = req_x ? GNT_X : IDLE;
        end else if (count_q == CNT_MAX) begin
          if (req_x) state_d = GNT_X;
          else       count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      count_d = '0;
      if (state_d == GNT_X)      last_d = LAST_X;
      else if (state_d == GNT_Y) last_d = LAST_Y;
    end
  end

  // Grant/select outputs are registered from the next state so they line up
  // with state_q without any output decode.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      last_q    <= LAST_Y;
      gnt_x_q   <= 1'b0;
      gnt_y_q   <= 1'b0;
      s_q       <= 1'b0;
      m_q       <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      last_q    <= last_d;
      gnt_x_q   <= (state_d == GNT_X);
      gnt_y_q   <= (state_d == GNT_Y);
      s_q       <= (state_d == GNT_Y);
      m_valid_q <= gnt_x_q | gnt_y_q;
      if (gnt_x_q | gnt_y_q) m_q <= mux_out;
    end
  end

  assign gnt_x   = gnt_x_q;
  assign gnt_y   = gnt_y_q;
  assign s       = s_q;
  assign m       = m_q;
  assign m_valid = m_valid_q;

`ifdef MUX_ARBITER_LED_EN
  // Pending flag is registered so every LED bit is zero while in reset.
  logic pend_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pend_q <= 1'b0;
    else         pend_q <= req_x & req_y;
  end

  assign LEDR = {3'(count_q), pend_q, gnt_y_q, gnt_x_q};
`else
  assign LEDR = '0;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  localparam int WIDTH = 8;
  localparam int HOLD  = 4;

  logic             clock  = 1'b0;
  logic             resetn = 1'b0;
  logic             req_x  = 1'b0;
  logic             req_y  = 1'b0;
  logic [WIDTH-1:0] x      = '0;
  logic [WIDTH-1:0] y      = '0;
  logic             gnt_x, gnt_y, s, m_valid;
  logic [WIDTH-1:0] m;
  logic [9:4]       LEDR;

  mux_arbiter #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .req_x   (req_x),
    .req_y   (req_y),
    .x       (x),
    .y       (y),
    .gnt_x   (gnt_x),
    .gnt_y   (gnt_y),
    .s       (s),
    .m       (m),
    .m_valid (m_valid),
    .LEDR    (LEDR)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner 0=none 1=X 2=Y; tenure = grant cycles since entry.
  int         owner, tenure, last_win, nxt;
  logic [7:0] mdl_m;
  logic       mdl_mv, mdl_pend;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner = 0; tenure = 0; last_win = 2;
      mdl_m = '0; mdl_mv = 1'b0; mdl_pend = 1'b0;
    end else begin
      mdl_mv   = (owner != 0);
      if (owner == 1)      mdl_m = x;
      else if (owner == 2) mdl_m = y;
      mdl_pend = req_x & req_y;
      if (owner == 0) begin
        if (req_x && req_y) nxt = (last_win == 1) ? 2 : 1;
        else if (req_x)     nxt = 1;
        else if (req_y)     nxt = 2;
        else                nxt = 0;
      end else begin
        logic mine, other;
        mine  = (owner == 1) ? req_x : req_y;
        other = (owner == 1) ? req_y : req_x;
        if (!mine)                               nxt = other ? 3 - owner : 0;
        else if (other && (tenure % HOLD) == 0)  nxt = 3 - owner;
        else                                     nxt = owner;
      end
      if (nxt != owner) begin
        tenure = (nxt != 0) ? 1 : 0;
        if (nxt != 0) last_win = nxt;
        owner = nxt;
      end else if (owner != 0) begin
        tenure++;
      end
    end
  end

  function automatic logic [9:4] exp_led();
    int cnt;
    cnt = (owner != 0) ? (tenure - 1) % HOLD : 0;
`ifdef MUX_ARBITER_LED_EN
    return {3'(cnt), mdl_pend, owner == 2, owner == 1};
`else
    return 6'b0;
`endif
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      chk("gnt_x", gnt_x, owner == 1);
      chk("gnt_y", gnt_y, owner == 2);
      chk("s", s, owner == 2);
      chk("m", m, mdl_m);
      chk("m_valid", m_valid, mdl_mv);
      chk("count", dut.count_q, (owner != 0) ? (tenure - 1) % HOLD : 0);
      chk("LEDR", LEDR, exp_led());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_gnt", {gnt_x, gnt_y, s}, 3'b000);
    chk("rst_m", {m_valid, m}, 9'h000);
    chk("rst_led", LEDR, 6'b0);
    @(negedge clock);
    resetn = 1'b1;

    // tie after reset: X wins, preempted by Y after 4 grant cycles
    tick();
    req_x = 1; req_y = 1; x = 8'hA5; y = 8'h3C;
    tick();
    chk("tie_x", gnt_x, 1'b1);
`ifdef MUX_ARBITER_LED_EN
    chk("led_tie", LEDR, 6'b000101);
`else
    chk("led_off", LEDR, 6'b0);
`endif
    tick();
    chk("tie_m_a5", m, 8'hA5);
    chk("tie_mv", m_valid, 1'b1);
    tick();
    tick();
    chk("hold4_x", {gnt_x, gnt_y}, 2'b10);
    tick();
    chk("preempt_y", {gnt_x, gnt_y, s}, 3'b011);
`ifdef MUX_ARBITER_LED_EN
    chk("led_pre", LEDR, 6'b000110);
`else
    chk("led_off2", LEDR, 6'b0);
`endif
    tick();
    chk("pre_m_3c", m, 8'h3C);

    // early release handoff Y -> X -> Y
    req_y = 0;
    tick();
    chk("rel_to_x", {gnt_x, gnt_y}, 2'b10);
    req_y = 1;
    tick();
    req_x = 0;
    tick();
    chk("early_rel", {gnt_x, gnt_y}, 2'b01);

    // idle return
    tick();
    req_y = 0;
    tick();
    chk("idle_gnt", {gnt_x, gnt_y, m_valid}, 3'b001);
    tick();
    chk("idle_mv", m_valid, 1'b0);
    chk("idle_m", m, 8'h3C);
    y = 8'h77;
    tick();
    chk("idle_hold", m, 8'h3C);

    // single requester Y for 10 cycles
    req_y = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("solo_y", {gnt_y, s}, 2'b11);
      chk("solo_cnt", dut.count_q, i % 4);
      if (i < 9) tick();
    end
    req_y = 0;
    tick();
    tick();

    // tie when X won last goes to Y
    req_x = 1;
    tick();
    req_x = 0;
    tick();
    req_x = 1; req_y = 1;
    tick();
    chk("tie_last_x", {gnt_x, gnt_y}, 2'b01);

    // async reset mid-grant
    req_y = 0;
    tick();
    tick();
    chk("pre_rst_m", {m_valid, m}, 9'h1A5);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_gnt", gnt_x, 1'b0);
    chk("arst_m", {m_valid, m}, 9'h000);
    chk("arst_led", LEDR, 6'b0);
    @(negedge clock);
    resetn = 1'b1;
    req_y = 1;
    tick();
    chk("post_rst_tie", {gnt_x, gnt_y}, 2'b10);

    // mixed request patterns
    for (int i = 0; i < 60; i++) begin
      req_x = (i % 5) != 0;
      req_y = (i % 7) != 3;
      x = 8'(i * 7);
      y = 8'(~i);
      tick();
    end
    req_x = 0; req_y = 0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
